// File: rtl/logic_edge_monitor_pkg.sv
// logic_edge_monitor_pkg
//   Shared types for the logic edge monitor: FSM state encoding, the per-event
//   flag pair carried alongside each timestamp, and default widths.
//   The optional unknown-cycle counter is enabled by the macro
//   LOGIC_EDGE_MONITOR_XCOUNT_EN (see logic_edge_monitor.sv).
package logic_edge_monitor_pkg;

  localparam int TS_W_DEFAULT  = 16;
  localparam int DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SNAP = 2'd1,
    RUN  = 2'd2
  } state_e;

  // Value/unknown pair of one sample. The full event record is
  // {ts[TS_W-1:0], ev_flags_t}; it is declared in the top so it can follow TS_W.
  typedef struct packed {
    logic val;
    logic x;
  } ev_flags_t;

  // A sample whose unknown rail is set is recorded with val forced to 0, so
  // equal X samples compare equal regardless of the value rail.
  function automatic ev_flags_t make_flags(input logic val, input logic x);
    ev_flags_t f;
    f.val = val & ~x;
    f.x   = x;
    return f;
  endfunction

endpackage

// File: rtl/logic_edge_monitor_fifo.sv
// logic_edge_monitor_fifo
//   Synchronous show-ahead FIFO of DEPTH entries (power of 2, >= 2).
//   Full/empty are derived from read/write pointers carrying an extra wrap bit.
//   Ports:
//     clk, rst_n        clock, synchronous active-low reset (pointers only)
//     push_i, data_i    write request and data; ignored when full unless popping
//     pop_i             read request; ignored when empty (no bypass)
//     data_o            head entry, valid while empty_o = 0
//     empty_o, full_o   occupancy flags
module logic_edge_monitor_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A pop frees the head slot in the same edge, so a push into a full FIFO
  // succeeds when it coincides with a pop. A pop on an empty FIFO is dropped,
  // so a simultaneous push is never bypassed to the output.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  assign data_o = mem_q[rd_ptr_q[AW-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; entries are only ever read
  // behind the pointers, which are reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/logic_edge_monitor.sv
// logic_edge_monitor
//   Observes a dual-rail (value/unknown) single-bit signal, emits a timestamped
//   event on every value or unknown-state change and queues the events in a
//   show-ahead FIFO drained over a valid/ready handshake.
//   Ports:
//     clk, rst_n          clock, synchronous active-low reset
//     en                  monitor enable (IDLE -> SNAP -> RUN)
//     sig_val, sig_x      observed value rail / unknown rail (1 = X)
//     ev_valid, ev_ready  event handshake; pop when both are high
//     ev_ts, ev_val, ev_x head event record (all 0 while the FIFO is empty)
//     overflow            sticky: at least one event was dropped
//     x_cycles            sampled cycles with sig_x = 1, saturating; present
//                         only when LOGIC_EDGE_MONITOR_XCOUNT_EN is defined
module logic_edge_monitor
  import logic_edge_monitor_pkg::*;
#(
  parameter int TS_W  = TS_W_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            sig_val,
  input  logic            sig_x,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [TS_W-1:0] ev_ts,
  output logic            ev_val,
  output logic            ev_x,
  output logic            overflow
`ifdef LOGIC_EDGE_MONITOR_XCOUNT_EN
  ,
  output logic [TS_W-1:0] x_cycles
`endif
);

  typedef struct packed {
    logic [TS_W-1:0] ts;
    ev_flags_t       flags;
  } ev_rec_t;

  localparam int REC_W = $bits(ev_rec_t);

  state_e          state_q, state_d;
  logic [TS_W-1:0] ts_q, ts_d;
  ev_flags_t       prev_q, prev_d;
  logic            overflow_q, overflow_d;

  ev_flags_t cur;
  ev_rec_t   push_rec, head_rec;
  logic      sampling, changed, ev_push, fifo_empty, fifo_full, dropped;

  assign cur      = make_flags(sig_val, sig_x);
  assign sampling = (state_q != IDLE);
  // X->X is never a change: both records carry val=0 once masked.
  assign changed  = (cur != prev_q);
  assign push_rec = '{ts: ts_q, flags: cur};
  assign dropped  = ev_push & fifo_full & ~(ev_ready & ~fifo_empty);

  // NOTE: every signal written here gets a default first so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d    = state_q;
    ev_push    = 1'b0;
    ts_d       = '0;
    prev_d     = prev_q;
    overflow_d = overflow_q | dropped;
    case (state_q)
      IDLE: if (en) state_d = SNAP;
      SNAP: begin
        ev_push = 1'b1;
        state_d = en ? RUN : IDLE;
      end
      RUN: begin
        ev_push = changed;
        if (!en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // ts is 0 in IDLE, so SNAP always records ts=0; it wraps silently.
    if (sampling) begin
      ts_d   = ts_q + TS_W'(1);
      prev_d = cur;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ts_q       <= '0;
      prev_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      prev_q     <= prev_d;
      overflow_q <= overflow_d;
    end
  end

  logic [REC_W-1:0] head_bits;

  logic_edge_monitor_fifo #(
    .WIDTH (REC_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ev_push),
    .data_i  (push_rec),
    .pop_i   (ev_ready),
    .data_o  (head_bits),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Storage is unreset, so the head is masked while empty to give clean zeros.
  assign head_rec = fifo_empty ? '0 : ev_rec_t'(head_bits);
  assign ev_valid = ~fifo_empty;
  assign ev_ts    = head_rec.ts;
  assign ev_val   = head_rec.flags.val;
  assign ev_x     = head_rec.flags.x;
  assign overflow = overflow_q;

`ifdef LOGIC_EDGE_MONITOR_XCOUNT_EN
  logic [TS_W-1:0] x_cnt_q, x_cnt_d;

  always_comb begin
    x_cnt_d = x_cnt_q;
    if (sampling && cur.x && (x_cnt_q != '1)) x_cnt_d = x_cnt_q + TS_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) x_cnt_q <= '0;
    else        x_cnt_q <= x_cnt_d;
  end

  assign x_cycles = x_cnt_q;
`endif

endmodule
